// File: rtl/adder_resp_checker.sv
// Exhaustive stimulus/response checker for small adder blocks: sweeps every {b,a}
// operand pair, compares the DUT's {carry,sum} against a+b and records the first failure.
module adder_resp_checker #(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 0,
   parameter int ERR_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   input  logic [WIDTH-1:0]   sum_in,
   input  logic               carry_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_cnt,
   output logic               first_err_vld,
   output logic [2*WIDTH-1:0] first_err_vec
);

   localparam int IDX_W = 2 * WIDTH;
   localparam int WC_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(LATENCY);
   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       rst_pipe;
   logic             core_rst;
   logic [IDX_W-1:0] idx;
   logic [WC_W-1:0]  wcnt;
   logic [WIDTH:0]   exp_v;
   logic [WIDTH:0]   resp;
   logic             go;
   logic             sample;
   logic             mismatch;
   logic             last_chk;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_pipe <= 2'b11;
      else     rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign core_rst = rst_pipe[1];

   assign go       = start && (state != APPLY);
   assign sample   = (state == APPLY) && (wcnt == WC_LAST);
   assign exp_v    = {1'b0, a_out} + {1'b0, b_out};
   assign resp     = {carry_in, sum_in};
   assign mismatch = sample && (resp != exp_v);
   assign last_chk = sample && (idx == IDX_LAST);

   always_ff @(posedge clk or posedge core_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (core_rst) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (start)    state_nxt = APPLY;
         APPLY:   if (last_chk) state_nxt = DONE;
         DONE:    if (start)    state_nxt = APPLY;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge core_rst) begin
      if (core_rst) begin
         idx           <= '0;
         wcnt          <= '0;
         err_cnt       <= '0;
         first_err_vld <= 1'b0;
         first_err_vec <= '0;
      end else if (go) begin
         idx           <= '0;
         wcnt          <= '0;
         err_cnt       <= '0;
         first_err_vld <= 1'b0;
         first_err_vec <= '0;
      end else if (state == APPLY) begin
         if (!sample) begin
            wcnt <= wcnt + 1'b1;
         end else begin
            if (mismatch) begin
               if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
               if (!first_err_vld) begin
                  first_err_vec <= {b_out, a_out};
                  first_err_vld <= 1'b1;
               end
            end
            // The final vector stays on the outputs once the sweep ends.
            if (!last_chk) begin
               idx  <= idx + 1'b1;
               wcnt <= '0;
            end
         end
      end
   end

   assign a_out = idx[WIDTH-1:0];
   assign b_out = idx[IDX_W-1:WIDTH];
   assign busy  = (state == APPLY);
   assign done  = (state == DONE);
   assign pass  = done && (err_cnt == '0);

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench: six checker instances each paired with a small adder model (good,
// faulty or pipelined), all swept together from a shared start/rst.
module tb_adder_resp_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // u1: correct half adder
   logic       a1, b1, s1, c1, busy1, done1, pass1, fv1;
   logic [7:0] e1;
   logic [1:0] fe1;
   assign {c1, s1} = {1'b0, a1} + {1'b0, b1};
   adder_resp_checker #(.WIDTH(1), .LATENCY(0), .ERR_W(8)) u1 (
      .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1), .sum_in(s1),
      .carry_in(c1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(e1),
      .first_err_vld(fv1), .first_err_vec(fe1));

   // u2: carry stuck at 0
   logic       a2, b2, s2, busy2, done2, pass2, fv2;
   logic [7:0] e2;
   logic [1:0] fe2;
   assign s2 = a2 ^ b2;
   adder_resp_checker #(.WIDTH(1), .LATENCY(0), .ERR_W(8)) u2 (
      .clk(clk), .rst(rst), .start(start), .a_out(a2), .b_out(b2), .sum_in(s2),
      .carry_in(1'b0), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(e2),
      .first_err_vld(fv2), .first_err_vec(fe2));

   // u3: sum inverted
   logic       a3, b3, s3, c3, busy3, done3, pass3, fv3;
   logic [7:0] e3;
   logic [1:0] fe3;
   assign s3 = ~(a3 ^ b3);
   assign c3 = a3 & b3;
   adder_resp_checker #(.WIDTH(1), .LATENCY(0), .ERR_W(8)) u3 (
      .clk(clk), .rst(rst), .start(start), .a_out(a3), .b_out(b3), .sum_in(s3),
      .carry_in(c3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(e3),
      .first_err_vld(fv3), .first_err_vec(fe3));

   // u4: two-stage pipelined half adder, checker LATENCY=2
   logic       a4, b4, busy4, done4, pass4, fv4;
   logic [1:0] p4a, p4b;
   logic [7:0] e4;
   logic [1:0] fe4;
   always_ff @(posedge clk) begin
      p4a <= {a4 & b4, a4 ^ b4};
      p4b <= p4a;
   end
   adder_resp_checker #(.WIDTH(1), .LATENCY(2), .ERR_W(8)) u4 (
      .clk(clk), .rst(rst), .start(start), .a_out(a4), .b_out(b4), .sum_in(p4b[0]),
      .carry_in(p4b[1]), .busy(busy4), .done(done4), .pass(pass4), .err_cnt(e4),
      .first_err_vld(fv4), .first_err_vec(fe4));

   // u5: same two-stage adder, checker under-provisioned at LATENCY=1
   logic       a5, b5, busy5, done5, pass5, fv5;
   logic [1:0] p5a, p5b;
   logic [7:0] e5;
   logic [1:0] fe5;
   always_ff @(posedge clk) begin
      p5a <= {a5 & b5, a5 ^ b5};
      p5b <= p5a;
   end
   adder_resp_checker #(.WIDTH(1), .LATENCY(1), .ERR_W(8)) u5 (
      .clk(clk), .rst(rst), .start(start), .a_out(a5), .b_out(b5), .sum_in(p5b[0]),
      .carry_in(p5b[1]), .busy(busy5), .done(done5), .pass(pass5), .err_cnt(e5),
      .first_err_vld(fv5), .first_err_vec(fe5));

   // u6: 2-bit adder with inverted sum, 2-bit saturating error counter
   logic [1:0] a6, b6, s6, fe6_lo;
   logic       c6, busy6, done6, pass6, fv6;
   logic [1:0] e6;
   logic [3:0] fe6;
   assign {c6, fe6_lo} = {1'b0, a6} + {1'b0, b6};
   assign s6 = ~fe6_lo;
   adder_resp_checker #(.WIDTH(2), .LATENCY(0), .ERR_W(2)) u6 (
      .clk(clk), .rst(rst), .start(start), .a_out(a6), .b_out(b6), .sum_in(s6),
      .carry_in(c6), .busy(busy6), .done(done6), .pass(pass6), .err_cnt(e6),
      .first_err_vld(fv6), .first_err_vec(fe6));

   logic [5:0] done_v;
   assign done_v = {done6, done5, done4, done3, done2, done1};
   int done_cyc[6];

   // Pulse start, then count edges until each instance raises done (bounded at 40).
   task automatic sweep(input bit inject_start);
      for (int i = 0; i < 6; i++) done_cyc[i] = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 6; i++)
            if (done_v[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
         start = (inject_start && cyc == 2);
      end
   endtask

   task automatic check_lengths(input string pfx);
      check({pfx, "u1_len"}, done_cyc[0], 4);
      check({pfx, "u2_len"}, done_cyc[1], 4);
      check({pfx, "u3_len"}, done_cyc[2], 4);
      check({pfx, "u4_len"}, done_cyc[3], 12);
      check({pfx, "u5_len"}, done_cyc[4], 8);
      check({pfx, "u6_len"}, done_cyc[5], 16);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  busy1, 0);
      check("rst_done",  done1, 0);
      check("rst_pass",  pass1, 0);
      check("rst_err",   e1, 0);
      check("rst_fvld",  fv1, 0);
      check("rst_ops",   {b6, a6}, 0);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);

      sweep(1'b0);
      check_lengths("");
      check("u1_pass", pass1, 1);
      check("u1_err",  e1, 0);
      check("u1_fvld", fv1, 0);
      check("u1_busy", busy1, 0);
      check("u1_hold", {b1, a1}, 2'b11);
      check("u2_err",  e2, 1);
      check("u2_fvec", fe2, 2'b11);
      check("u2_pass", pass2, 0);
      check("u3_err",  e3, 4);
      check("u3_fvec", fe3, 2'b00);
      check("u3_fvld", fv3, 1);
      check("u4_pass", pass4, 1);
      check("u4_err",  e4, 0);
      check("u5_errnz", (e5 != 0), 1);
      check("u5_pass", pass5, 0);
      check("u6_err",  e6, 3);
      check("u6_fvec", fe6, 4'b0000);
      check("u6_hold", {b6, a6}, 4'b1111);

      // Restart from DONE, then abort with rst at cycle 2.
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("rs_busy", busy1, 1);
      check("rs_done", done1, 0);
      check("rs_u3err", e3, 0);
      check("rs_u3fvld", fv3, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("ab_u3err",  e3, 0);
      check("ab_u3fvld", fv3, 0);
      check("ab_u3fvec", fe3, 0);
      check("ab_busy",   busy3, 0);
      check("ab_done",   done3, 0);
      check("ab_ops",    {b3, a3}, 0);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);

      // Start pulsed mid-sweep must not change any sweep length or result.
      sweep(1'b1);
      check_lengths("ms_");
      check("ms_u1pass", pass1, 1);
      check("ms_u3err",  e3, 4);
      check("ms_u6err",  e6, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
